// File: rtl/tsc_pkg.sv
// rtl/tsc_pkg.sv - shared constants and types for the transient-signal-capture controller
//
// Purpose: FSM state encoding, ring-buffer geometry and the default
// parameter values shared by tsc and tsc_adc.
// Ports: none (package).

package tsc_pkg;

  localparam int BUF_DEPTH = 32;
  localparam int PTR_W     = 5;
  localparam int DATA_W    = 8;

  localparam int DEF_ADC_STEP   = 8;
  localparam int DEF_TRIG_LEVEL = 128;
  localparam int DEF_POST_TRIG  = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_POST = 3'd2,
    ST_WAIT = 3'd3,
    ST_SEND = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Ring-buffer pointer advance; the 5-bit width gives the 31 -> 0 wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/tsc_if.sv
// rtl/tsc_if.sv - hub handshake interface of the capture controller
//
// Purpose: groups the hub-facing control and serial signals.
// Signals:
//   start   : arm/begin capture (hub -> controller)
//   SBF     : "send buffer" request (hub -> controller)
//   TRD_out : trigger done, buffer ready (controller -> hub)
//   SD_out  : serial data, MSB first (controller -> hub)
//   CD_out  : send complete (controller -> hub)
// Modports: master = hub side, slave = controller side.

interface tsc_if;

  logic start;
  logic SBF;
  logic TRD_out;
  logic SD_out;
  logic CD_out;

  modport master (
    output start,
    output SBF,
    input  TRD_out,
    input  SD_out,
    input  CD_out
  );

  modport slave (
    input  start,
    input  SBF,
    output TRD_out,
    output SD_out,
    output CD_out
  );

endinterface

// File: rtl/tsc_adc.sv
// rtl/tsc_adc.sv - on-chip ADC model producing a ramp of samples
//
// Purpose: while active, alternates a request cycle and a ready cycle;
// each ready cycle presents sample n*ADC_STEP (mod 256) and advances n.
// The sample index survives re-arming and is cleared only by reset.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   active     : the controller will be capturing in the coming cycle
//   request    : conversion request (registered)
//   ready      : sample valid (registered)
//   data       : last sample, held while not ready

module tsc_adc
  import tsc_pkg::*;
#(
  parameter int ADC_STEP = DEF_ADC_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  output logic              request,
  output logic              ready,
  output logic [DATA_W-1:0] data
);

  localparam logic [DATA_W-1:0] STEP8 = DATA_W'(ADC_STEP);

  logic              phase;       // 0: next cycle is a request cycle, 1: next is a ready cycle
  logic [DATA_W-1:0] sample_idx;  // kept mod 256, enough since data is mod 256

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= 1'b0;
      request    <= 1'b0;
      ready      <= 1'b0;
      data       <= '0;
      sample_idx <= '0;
    end else if (!active) begin
      // Dropping out of capture restarts the pattern at a request cycle.
      phase   <= 1'b0;
      request <= 1'b0;
      ready   <= 1'b0;
    end else if (!phase) begin
      phase   <= 1'b1;
      request <= 1'b1;
      ready   <= 1'b0;
    end else begin
      phase      <= 1'b0;
      request    <= 1'b0;
      ready      <= 1'b1;
      data       <= sample_idx * STEP8;
      sample_idx <= sample_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tsc.sv
// rtl/tsc.sv - transient-signal-capture controller top
//
// Purpose: captures ADC samples into a 32-entry ring buffer, waits for a
// level trigger, captures POST_TRIG more samples, signals TRD to the hub,
// and on SBF streams the whole buffer oldest byte first, MSB first, on SD.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   hub                   : tsc_if.slave (start, SBF, TRD_out, SD_out, CD_out)
//   state_out             : FSM state
//   adc_request_out       : ADC conversion request
//   adc_ready_out         : ADC data valid
//   adc_data_out          : ADC sample
//   read_ptr_out          : ring-buffer read pointer
//   write_ptr_out         : ring-buffer write pointer
//   ring_buffer_read_ptr  : buffer[read_ptr] (combinational)
//   ring_buffer_write_ptr : buffer[write_ptr] (combinational)
//   remaining_values_out  : post-trigger samples still to capture
//   adc_triggered_out     : trigger has fired this run
//   TRIGTM_out            : timer value latched at trigger

module tsc
  import tsc_pkg::*;
#(
  parameter int ADC_STEP   = DEF_ADC_STEP,
  parameter int TRIG_LEVEL = DEF_TRIG_LEVEL,
  parameter int POST_TRIG  = DEF_POST_TRIG
) (
  input  logic              clk,
  input  logic              reset,
  tsc_if.slave              hub,
  output logic [2:0]        state_out,
  output logic              adc_request_out,
  output logic              adc_ready_out,
  output logic [DATA_W-1:0] adc_data_out,
  output logic [PTR_W-1:0]  read_ptr_out,
  output logic [PTR_W-1:0]  write_ptr_out,
  output logic [DATA_W-1:0] ring_buffer_read_ptr,
  output logic [DATA_W-1:0] ring_buffer_write_ptr,
  output logic [PTR_W-1:0]  remaining_values_out,
  output logic              adc_triggered_out,
  output logic [31:0]       TRIGTM_out
);

  localparam logic [DATA_W-1:0] TRIG8     = DATA_W'(TRIG_LEVEL);
  localparam logic [PTR_W-1:0]  POST5     = PTR_W'(POST_TRIG);
  localparam logic              NO_POST   = (POST_TRIG == 0);
  localparam logic [PTR_W-1:0]  LAST_BYTE = PTR_W'(BUF_DEPTH - 1);

  state_t            state;
  logic [DATA_W-1:0] buffer [BUF_DEPTH];
  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic [PTR_W-1:0]  remaining;
  logic              triggered;
  logic [31:0]       trigtm;
  logic [31:0]       timer;
  logic              trd;
  logic              sd;
  logic              cd;
  logic [2:0]        bit_pos;   // index of the bit currently on SD
  logic [PTR_W-1:0]  byte_cnt;  // bytes fully sent before the current one

  logic              adc_active;
  logic              adc_request;
  logic              adc_ready;
  logic [DATA_W-1:0] adc_data;
  logic              trig_hit;
  logic              last_post;

  assign trig_hit  = adc_ready && (adc_data >= TRIG8);
  assign last_post = adc_ready && (remaining == PTR_W'(1));

  // The ADC outputs are registered, so it must see the state that will be
  // in force next cycle: start from IDLE/DONE turns it on immediately, and
  // the final capture edge turns it off so request/ready drop with WAIT.
  always_comb begin
    adc_active = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: adc_active = hub.start;
      ST_RUN:           adc_active = !(trig_hit && NO_POST);
      ST_POST:          adc_active = !last_post;
      default:          adc_active = 1'b0;
    endcase
  end

  tsc_adc #(
    .ADC_STEP (ADC_STEP)
  ) u_adc (
    .clk     (clk),
    .reset   (reset),
    .active  (adc_active),
    .request (adc_request),
    .ready   (adc_ready),
    .data    (adc_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wp        <= '0;
      rp        <= '0;
      remaining <= '0;
      triggered <= 1'b0;
      trigtm    <= '0;
      timer     <= '0;
      trd       <= 1'b0;
      sd        <= 1'b0;
      cd        <= 1'b0;
      bit_pos   <= '0;
      byte_cnt  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      timer <= timer + 1'b1;

      // Every captured sample lands in the ring, overwriting the oldest.
      if (adc_ready && (state == ST_RUN || state == ST_POST)) begin
        buffer[wp] <= adc_data;
        wp         <= ptr_inc(wp);
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (hub.start) begin
            state     <= ST_RUN;
            triggered <= 1'b0;
            cd        <= 1'b0;
            trigtm    <= '0;
            remaining <= '0;
          end
        end

        ST_RUN: begin
          if (trig_hit) begin
            triggered <= 1'b1;
            trigtm    <= timer;
            remaining <= POST5;
            if (NO_POST) begin
              state <= ST_WAIT;
              rp    <= ptr_inc(wp);
              trd   <= 1'b1;
            end else begin
              state <= ST_POST;
            end
          end
        end

        ST_POST: begin
          if (adc_ready) begin
            remaining <= remaining - 1'b1;
            if (last_post) begin
              // wp advances on this same edge; its new value is the oldest entry.
              state <= ST_WAIT;
              rp    <= ptr_inc(wp);
              trd   <= 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (hub.SBF) begin
            state    <= ST_SEND;
            trd      <= 1'b0;
            sd       <= buffer[rp][DATA_W-1];
            bit_pos  <= 3'd7;
            byte_cnt <= '0;
          end
        end

        ST_SEND: begin
          if (bit_pos == 3'd0) begin
            rp <= ptr_inc(rp);
            if (byte_cnt == LAST_BYTE) begin
              state <= ST_DONE;
              cd    <= 1'b1;
              sd    <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              bit_pos  <= 3'd7;
              sd       <= buffer[ptr_inc(rp)][DATA_W-1];
            end
          end else begin
            bit_pos <= bit_pos - 3'd1;
            sd      <= buffer[rp][bit_pos - 3'd1];
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign hub.TRD_out = trd;
  assign hub.SD_out  = sd;
  assign hub.CD_out  = cd;

  assign state_out             = state;
  assign adc_request_out       = adc_request;
  assign adc_ready_out         = adc_ready;
  assign adc_data_out          = adc_data;
  assign read_ptr_out          = rp;
  assign write_ptr_out         = wp;
  assign ring_buffer_read_ptr  = buffer[rp];
  assign ring_buffer_write_ptr = buffer[wp];
  assign remaining_values_out  = remaining;
  assign adc_triggered_out     = triggered;
  assign TRIGTM_out            = trigtm;

endmodule

// File: tb/tb_tsc.sv
// tb/tb_tsc.sv - scoreboard testbench for the capture controller

module tb_tsc;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  state_out;
  logic        adc_request_out;
  logic        adc_ready_out;
  logic [7:0]  adc_data_out;
  logic [4:0]  read_ptr_out;
  logic [4:0]  write_ptr_out;
  logic [7:0]  ring_buffer_read_ptr;
  logic [7:0]  ring_buffer_write_ptr;
  logic [4:0]  remaining_values_out;
  logic        adc_triggered_out;
  logic [31:0] TRIGTM_out;

  always #5 clk = ~clk;

  tsc_if hub();

  tsc #(
    .ADC_STEP   (8),
    .TRIG_LEVEL (128),
    .POST_TRIG  (16)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .hub                   (hub),
    .state_out             (state_out),
    .adc_request_out       (adc_request_out),
    .adc_ready_out         (adc_ready_out),
    .adc_data_out          (adc_data_out),
    .read_ptr_out          (read_ptr_out),
    .write_ptr_out         (write_ptr_out),
    .ring_buffer_read_ptr  (ring_buffer_read_ptr),
    .ring_buffer_write_ptr (ring_buffer_write_ptr),
    .remaining_values_out  (remaining_values_out),
    .adc_triggered_out     (adc_triggered_out),
    .TRIGTM_out            (TRIGTM_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [4:0]  wp;
    logic [4:0]  rp;
    logic [31:0] tm;
  } snap_t;

  logic [7:0] adc_q [$];
  logic       sd_q  [$];
  snap_t      trd_q [$];

  bit    mon_en   = 1'b0;
  logic  trd_prev = 1'b0;
  snap_t mon_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"},  state_out, 0);
    check({tag, "_req"},    adc_request_out, 0);
    check({tag, "_rdy"},    adc_ready_out, 0);
    check({tag, "_data"},   adc_data_out, 0);
    check({tag, "_rp"},     read_ptr_out, 0);
    check({tag, "_wp"},     write_ptr_out, 0);
    check({tag, "_rbuf"},   ring_buffer_read_ptr, 0);
    check({tag, "_wbuf"},   ring_buffer_write_ptr, 0);
    check({tag, "_remain"}, remaining_values_out, 0);
    check({tag, "_trig"},   adc_triggered_out, 0);
    check({tag, "_tm"},     TRIGTM_out, 0);
    check({tag, "_trd"},    hub.TRD_out, 0);
    check({tag, "_sd"},     hub.SD_out, 0);
    check({tag, "_cd"},     hub.CD_out, 0);
  endtask

  task automatic wait_trd(input string name);
    int n = 0;
    while (!hub.TRD_out && n < 300) begin
      tick();
      n++;
    end
    if (!hub.TRD_out) fail({name, "_timeout"});
  endtask

  task automatic push_stream(input int nbits);
    logic [7:0] b;
    int cnt = 0;
    for (int i = 0; i < 32; i++) begin
      b = 8'((i + 1) * 8);
      for (int j = 7; j >= 0; j--) begin
        if (cnt < nbits) sd_q.push_back(b[j]);
        cnt++;
      end
    end
  endtask

  // Monitor: pops expected values whenever the DUT presents a sample,
  // a serial bit, or a TRD rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (adc_ready_out) begin
        if (adc_q.size() == 0) fail("adc_unexpected");
        else check("adc_data", adc_data_out, adc_q.pop_front());
      end
      if (state_out == 3'd4) begin
        if (sd_q.size() == 0) fail("sd_unexpected");
        else check("sd_bit", hub.SD_out, sd_q.pop_front());
      end
      if (hub.TRD_out && !trd_prev) begin
        if (trd_q.size() == 0) fail("trd_unexpected");
        else begin
          mon_s = trd_q.pop_front();
          check("trd_wp",     write_ptr_out, mon_s.wp);
          check("trd_rp",     read_ptr_out, mon_s.rp);
          check("trd_tm",     TRIGTM_out, mon_s.tm);
          check("trd_trig",   adc_triggered_out, 1);
          check("trd_state",  state_out, 3);
          check("trd_remain", remaining_values_out, 0);
          check("trd_req",    adc_request_out, 0);
        end
      end
      trd_prev = hub.TRD_out;
    end
  end

  initial begin
    int r;
    int k;
    snap_t s;

    reset     = 1'b1;
    hub.start = 1'b0;
    hub.SBF   = 1'b0;
    tick();
    r     = cyc;
    reset = 1'b0;
    check_reset("rst");
    mon_en = 1'b1;

    // SBF outside WAIT is ignored.
    hub.SBF = 1'b1;
    tick();
    hub.SBF = 1'b0;
    check("idle_sbf_state", state_out, 0);
    check("idle_sbf_trd",   hub.TRD_out, 0);

    // First capture: samples 0..32, trigger on sample 16 (value 128).
    for (int n = 0; n <= 32; n++) adc_q.push_back(8'(n * 8));
    k    = cyc + 1;
    s.wp = 5'd1;
    s.rp = 5'd1;
    s.tm = 32'(k - r + 33);
    trd_q.push_back(s);
    hub.start = 1'b1;
    tick();
    hub.start = 1'b0;
    check("run_state", state_out, 1);
    check("run_req",   adc_request_out, 1);
    check("run_rdy",   adc_ready_out, 0);
    wait_trd("trd1");
    check("oldest_byte", ring_buffer_read_ptr, 8);

    // Hub answers 5 cycles after TRD.
    repeat (4) tick();
    check("trd_held", hub.TRD_out, 1);
    push_stream(256);
    hub.SBF = 1'b1;
    tick();
    hub.SBF = 1'b0;
    check("send_trd",   hub.TRD_out, 0);
    check("send_state", state_out, 4);
    repeat (255) tick();
    check("pre_cd",       hub.CD_out, 0);
    check("pre_cd_state", state_out, 4);
    tick();
    check("cd",         hub.CD_out, 1);
    check("done_state", state_out, 5);
    check("done_sd",    hub.SD_out, 0);
    check("done_rp",    read_ptr_out, 1);
    check("done_wp",    write_ptr_out, 1);
    check("sd_drained", sd_q.size(), 0);
    tick();
    check("cd_held", hub.CD_out, 1);

    // Re-arm: ADC sequence continues at sample 33; sample 48 (128) triggers.
    for (int n = 33; n <= 64; n++) adc_q.push_back(8'(n * 8));
    k    = cyc + 1;
    s.wp = 5'd1;
    s.rp = 5'd1;
    s.tm = 32'(k - r + 31);
    trd_q.push_back(s);
    hub.start = 1'b1;
    tick();
    hub.start = 1'b0;
    check("rearm_state",  state_out, 1);
    check("rearm_cd",     hub.CD_out, 0);
    check("rearm_trig",   adc_triggered_out, 0);
    check("rearm_tm",     TRIGTM_out, 0);
    check("rearm_remain", remaining_values_out, 0);
    check("rearm_wp",     write_ptr_out, 1);
    wait_trd("trd2");

    // Abort after 20 serial bits.
    push_stream(20);
    hub.SBF = 1'b1;
    tick();
    hub.SBF = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset("abort");

    check("adc_q_drained", adc_q.size(), 0);
    check("sd_q_drained",  sd_q.size(), 0);
    check("trd_q_drained", trd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
